// File: rtl/axi_pattern_burst_writer.sv
// AXI3 write-traffic generator: on a trigger, issues NBURSTS INCR bursts of BURST_LEN
// 32-bit beats from ADDR in STRIDE steps, with data from a reseedable pattern generator.
module axi_pattern_burst_writer #(
  parameter logic [31:0] ADDR      = 32'h0000_0000,
  parameter logic [31:0] STRIDE    = 32'h0000_0040,
  parameter int          NBURSTS   = 4,
  parameter int          BURST_LEN = 16,
  parameter logic [31:0] PTTN      = 32'h1234_5678,
  parameter int          MODE      = 0
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        trigger,
  // AXI3 write address channel
  output logic [3:0]  m_awid,
  output logic [31:0] m_awaddr,
  output logic [3:0]  m_awlen,
  output logic [2:0]  m_awsize,
  output logic [1:0]  m_awburst,
  output logic [1:0]  m_awlock,
  output logic [3:0]  m_awcache,
  output logic        m_awvalid,
  input  logic        m_awready,
  // AXI3 write data channel
  output logic [3:0]  m_wid,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  output logic        m_wlast,
  output logic        m_wvalid,
  input  logic        m_wready,
  // AXI3 write response channel
  input  logic [1:0]  m_bresp,
  input  logic        m_bvalid,
  output logic        m_bready,
  // read channel unused
  output logic        m_arvalid,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] burst_count,
  output logic [1:0]  dbg_state
);

  // Handshakes: a transfer happens on the rising edge where valid && ready are both high;
  // once valid is raised, the payload is held stable until that edge.

  // LFSR cannot run from an all-zero seed, so a zero seed becomes 1 in that mode.
  localparam logic [31:0] SEED      = (MODE == 2 && PTTN == 32'h0) ? 32'h1 : PTTN;
  localparam logic [3:0]  LAST_BEAT = 4'(BURST_LEN - 1);
  localparam logic [16:0] NB        = 17'(NBURSTS);

  typedef enum logic [1:0] {S_IDLE, S_WADDR, S_WDATA, S_WRESP} state_t;

  state_t      r_state, w_state_nxt;
  logic        r_awvalid, w_awvalid_nxt;
  logic        r_wvalid, w_wvalid_nxt;
  logic        r_wlast, w_wlast_nxt;
  logic        r_bready, w_bready_nxt;
  logic        r_busy, w_busy_nxt;
  logic        r_done, w_done_nxt;
  logic        r_err, w_err_nxt;
  logic [15:0] r_bcnt, w_bcnt_nxt;
  logic [31:0] r_addr, w_addr_nxt;
  logic [31:0] r_data, w_data_nxt;
  logic [3:0]  r_beat, w_beat_nxt;
  logic [16:0] w_bcnt_inc;

  function automatic logic [31:0] f_next(input logic [31:0] d);
    if (MODE == 1)      return d + 32'd1;
    else if (MODE == 2) return (d >> 1) ^ (d[0] ? 32'h8020_0003 : 32'h0);
    else                return {d[3:0], d[31:4]};
  endfunction

  assign w_bcnt_inc = {1'b0, r_bcnt} + 17'd1;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_awvalid_nxt = r_awvalid;
    w_wvalid_nxt  = r_wvalid;
    w_wlast_nxt   = r_wlast;
    w_bready_nxt  = r_bready;
    w_busy_nxt    = r_busy;
    w_done_nxt    = 1'b0;
    w_err_nxt     = r_err;
    w_bcnt_nxt    = r_bcnt;
    w_addr_nxt    = r_addr;
    w_data_nxt    = r_data;
    w_beat_nxt    = r_beat;
    case (r_state)
      S_IDLE: begin
        if (trigger) begin
          w_state_nxt   = S_WADDR;
          w_awvalid_nxt = 1'b1;
          w_busy_nxt    = 1'b1;
          w_addr_nxt    = ADDR;
          w_data_nxt    = SEED;
          w_beat_nxt    = 4'd0;
          w_err_nxt     = 1'b0;
          w_bcnt_nxt    = 16'd0;
        end
      end
      S_WADDR: begin
        if (m_awready) begin
          w_state_nxt   = S_WDATA;
          w_awvalid_nxt = 1'b0;
          w_wvalid_nxt  = 1'b1;
          w_wlast_nxt   = (LAST_BEAT == 4'd0);
        end
      end
      S_WDATA: begin
        if (m_wready) begin
          w_data_nxt = f_next(r_data);
          if (r_beat == LAST_BEAT) begin
            w_state_nxt  = S_WRESP;
            w_beat_nxt   = 4'd0;
            w_wvalid_nxt = 1'b0;
            w_wlast_nxt  = 1'b0;
            w_bready_nxt = 1'b1;
          end else begin
            w_beat_nxt  = r_beat + 4'd1;
            w_wlast_nxt = ((r_beat + 4'd1) == LAST_BEAT);
          end
        end
      end
      S_WRESP: begin
        if (m_bvalid) begin
          w_bready_nxt = 1'b0;
          w_bcnt_nxt   = w_bcnt_inc[15:0];
          w_err_nxt    = r_err | (m_bresp != 2'b00);
          if (w_bcnt_inc < NB) begin
            w_state_nxt   = S_WADDR;
            w_awvalid_nxt = 1'b1;
            w_addr_nxt    = r_addr + STRIDE;
          end else begin
            w_state_nxt = S_IDLE;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_wlast   <= 1'b0;
      r_bready  <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_bcnt    <= 16'd0;
      r_addr    <= ADDR;
      r_data    <= SEED;
      r_beat    <= 4'd0;
    end else begin
      r_awvalid <= w_awvalid_nxt;
      r_wvalid  <= w_wvalid_nxt;
      r_wlast   <= w_wlast_nxt;
      r_bready  <= w_bready_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_err     <= w_err_nxt;
      r_bcnt    <= w_bcnt_nxt;
      r_addr    <= w_addr_nxt;
      r_data    <= w_data_nxt;
      r_beat    <= w_beat_nxt;
    end
  end

  assign m_awid      = 4'd0;
  assign m_awaddr    = r_addr;
  assign m_awlen     = LAST_BEAT;
  assign m_awsize    = 3'd2;
  assign m_awburst   = 2'b01;
  assign m_awlock    = 2'b00;
  assign m_awcache   = 4'd0;
  assign m_awvalid   = r_awvalid;
  assign m_wid       = 4'd0;
  assign m_wdata     = r_data;
  assign m_wstrb     = 4'hF;
  assign m_wlast     = r_wlast;
  assign m_wvalid    = r_wvalid;
  assign m_bready    = r_bready;
  assign m_arvalid   = 1'b0;
  assign busy        = r_busy;
  assign done        = r_done;
  assign err         = r_err;
  assign burst_count = r_bcnt;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_axi_pattern_burst_writer.sv
// Bench for axi_pattern_burst_writer: three parameterisations checked every cycle
// against a transaction-level model, plus hand-computed literal expectations.
module tb_axi_pattern_burst_writer;

  localparam int NI = 3;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic        trigger[NI];
  logic [3:0]  awid[NI], awlen[NI], awcache[NI], wid[NI], wstrb[NI];
  logic [2:0]  awsize[NI];
  logic [1:0]  awburst[NI], awlock[NI], bresp[NI], dbg_state[NI];
  logic [31:0] awaddr[NI], wdata[NI];
  logic        awvalid[NI], awready[NI], wlast[NI], wvalid[NI], wready[NI];
  logic        bvalid[NI], bready[NI], arvalid[NI], busy[NI], done[NI], err[NI];
  logic [15:0] burst_count[NI];

  for (genvar k = 0; k < NI; k++) begin : g_dut
    axi_pattern_burst_writer #(
      .ADDR(32'h0), .STRIDE(32'h40),
      .NBURSTS(k == 1 ? 3 : 4),
      .BURST_LEN(k == 1 ? 1 : 16),
      .PTTN(k == 1 ? 32'd5 : (k == 2 ? 32'd0 : 32'h1234_5678)),
      .MODE(k)
    ) u_dut (
      .clk(clk), .rstn(rstn), .trigger(trigger[k]),
      .m_awid(awid[k]), .m_awaddr(awaddr[k]), .m_awlen(awlen[k]), .m_awsize(awsize[k]),
      .m_awburst(awburst[k]), .m_awlock(awlock[k]), .m_awcache(awcache[k]),
      .m_awvalid(awvalid[k]), .m_awready(awready[k]),
      .m_wid(wid[k]), .m_wdata(wdata[k]), .m_wstrb(wstrb[k]), .m_wlast(wlast[k]),
      .m_wvalid(wvalid[k]), .m_wready(wready[k]),
      .m_bresp(bresp[k]), .m_bvalid(bvalid[k]), .m_bready(bready[k]),
      .m_arvalid(arvalid[k]),
      .busy(busy[k]), .done(done[k]), .err(err[k]), .burst_count(burst_count[k]),
      .dbg_state(dbg_state[k])
    );
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] got=%h expected=%h t=%0t", nm, k, act, exp, $time);
    end
  endtask

  // Configuration as the model sees it
  function automatic int p_nb(input int k);   return (k == 1) ? 3 : 4;  endfunction
  function automatic int p_bl(input int k);   return (k == 1) ? 1 : 16; endfunction
  function automatic logic [31:0] p_seed(input int k);
    logic [31:0] pt;
    pt = (k == 1) ? 32'd5 : ((k == 2) ? 32'd0 : 32'h1234_5678);
    return (k == 2 && pt == 32'd0) ? 32'd1 : pt;
  endfunction
  function automatic logic [31:0] gen_next(input int k, input logic [31:0] d);
    if (k == 0) return (d >> 4) | (d << 28);
    if (k == 1) return d + 32'd1;
    return d[0] ? ((d >> 1) ^ 32'h8020_0003) : (d >> 1);
  endfunction

  // Model: ph 0 idle, 1 address phase, 2 data phase, 3 response phase
  int          ph[NI], m_beat[NI], m_aw_n[NI], m_bcnt[NI];
  logic [31:0] m_data[NI];
  logic        m_err[NI], m_done[NI];
  logic [31:0] log_aw[NI][8], log_w[NI][8];
  logic        log_last[NI][8];
  int          n_aw[NI], n_w[NI];
  bit          stall = 0;
  int          err_burst = 0;

  always @(negedge clk) begin
    for (int k = 0; k < NI; k++) begin
      if (!rstn) begin
        ph[k] = 0; m_beat[k] = 0; m_aw_n[k] = 0; m_bcnt[k] = 0;
        m_err[k] = 1'b0; m_done[k] = 1'b0;
      end
      chk("busy", k, 32'(busy[k]), 32'(ph[k] != 0));
      chk("done", k, 32'(done[k]), 32'(m_done[k]));
      chk("err", k, 32'(err[k]), 32'(m_err[k]));
      chk("burst_count", k, 32'(burst_count[k]), 32'(m_bcnt[k]));
      chk("awvalid", k, 32'(awvalid[k]), 32'(ph[k] == 1));
      chk("wvalid", k, 32'(wvalid[k]), 32'(ph[k] == 2));
      chk("bready", k, 32'(bready[k]), 32'(ph[k] == 3));
      chk("arvalid", k, 32'(arvalid[k]), 32'd0);
      if (ph[k] == 1) begin
        chk("awaddr", k, awaddr[k], 32'(m_aw_n[k]) * 32'h40);
        chk("awlen", k, 32'(awlen[k]), 32'(p_bl(k) - 1));
        chk("aw_const", k, {awid[k], awsize[k], awburst[k], awlock[k], awcache[k]},
            {4'd0, 3'd2, 2'd1, 2'd0, 4'd0});
      end
      if (ph[k] == 2) begin
        chk("wdata", k, wdata[k], m_data[k]);
        chk("wlast", k, 32'(wlast[k]), 32'(m_beat[k] == p_bl(k) - 1));
        chk("wstrb", k, 32'(wstrb[k]), 32'hF);
      end
      awready[k] = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      wready[k]  = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      bvalid[k]  = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      bresp[k]   = (m_bcnt[k] + 1 == err_burst) ? 2'b10 : 2'b00;
      if (rstn) begin
        m_done[k] = 1'b0;
        case (ph[k])
          0: if (trigger[k]) begin
            ph[k] = 1; m_data[k] = p_seed(k); m_beat[k] = 0;
            m_aw_n[k] = 0; m_bcnt[k] = 0; m_err[k] = 1'b0;
          end
          1: if (awready[k]) begin
            if (awvalid[k] && n_aw[k] < 8) log_aw[k][n_aw[k]] = awaddr[k];
            if (awvalid[k]) n_aw[k]++;
            ph[k] = 2;
          end
          2: if (wready[k]) begin
            if (wvalid[k] && n_w[k] < 8) begin
              log_w[k][n_w[k]] = wdata[k];
              log_last[k][n_w[k]] = wlast[k];
            end
            if (wvalid[k]) n_w[k]++;
            m_data[k] = gen_next(k, m_data[k]);
            if (m_beat[k] == p_bl(k) - 1) begin
              m_beat[k] = 0; ph[k] = 3;
            end else m_beat[k]++;
          end
          3: if (bvalid[k]) begin
            m_bcnt[k]++;
            m_err[k] = m_err[k] | (bresp[k] != 2'b00);
            if (m_bcnt[k] == p_nb(k)) begin
              ph[k] = 0; m_done[k] = 1'b1;
            end else begin
              ph[k] = 1; m_aw_n[k]++;
            end
          end
          default: ph[k] = 0;
        endcase
      end
    end
  end

  task automatic clear_logs(input int k);
    n_aw[k] = 0;
    n_w[k] = 0;
  endtask

  task automatic pulse(input int k);
    @(posedge clk); #1 trigger[k] = 1'b1;
    @(posedge clk); #1 trigger[k] = 1'b0;
  endtask

  task automatic wait_done(input int k, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk); #1;
      if (done[k]) seen = 1'b1;
    end
    chk("done_timeout", k, 32'(seen), 32'd1);
  endtask

  initial begin
    for (int k = 0; k < NI; k++) begin
      trigger[k] = 1'b0; n_aw[k] = 0; n_w[k] = 0;
    end
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk); #1;
    chk("reset_state", 0, 32'(dbg_state[0]), 32'd0);
    chk("reset_wdata", 0, wdata[0], 32'h1234_5678);
    chk("reset_seed_lfsr", 2, wdata[2], 32'h1);

    // Defaults, always-ready slave
    clear_logs(0);
    pulse(0);
    wait_done(0, 500);
    chk("t1_naw", 0, 32'(n_aw[0]), 32'd4);
    chk("t1_aw1", 0, log_aw[0][1], 32'h40);
    chk("t1_aw2", 0, log_aw[0][2], 32'h80);
    chk("t1_aw3", 0, log_aw[0][3], 32'hC0);
    chk("t1_beat0", 0, log_w[0][0], 32'h1234_5678);
    chk("t1_beat1", 0, log_w[0][1], 32'h8123_4567);
    chk("t1_nbeats", 0, 32'(n_w[0]), 32'd64);

    // Single-beat bursts, increment pattern
    clear_logs(1);
    pulse(1);
    wait_done(1, 200);
    chk("t2_nbeats", 1, 32'(n_w[1]), 32'd3);
    chk("t2_d0", 1, log_w[1][0], 32'd5);
    chk("t2_d1", 1, log_w[1][1], 32'd6);
    chk("t2_d2", 1, log_w[1][2], 32'd7);
    chk("t2_lasts", 1, {29'd0, log_last[1][0], log_last[1][1], log_last[1][2]}, 32'd7);
    chk("t2_bcnt", 1, 32'(burst_count[1]), 32'd3);

    // Random stalls on every channel
    stall = 1'b1;
    clear_logs(0);
    pulse(0);
    wait_done(0, 3000);
    chk("t3_nbeats", 0, 32'(n_w[0]), 32'd64);
    chk("t3_aw3", 0, log_aw[0][3], 32'hC0);
    stall = 1'b0;

    // SLVERR on the second burst only
    err_burst = 2;
    pulse(0);
    wait_done(0, 500);
    chk("t4_err_at_done", 0, 32'(err[0]), 32'd1);
    err_burst = 0;
    repeat (3) @(posedge clk);
    chk("t4_err_held", 0, 32'(err[0]), 32'd1);
    pulse(0);
    @(negedge clk); #1;
    chk("t4_err_cleared", 0, 32'(err[0]), 32'd0);
    wait_done(0, 500);
    chk("t4_err_clean_run", 0, 32'(err[0]), 32'd0);

    // LFSR from zero seed; trigger held high mid-run must not restart
    clear_logs(2);
    @(posedge clk); #1 trigger[2] = 1'b1;
    repeat (30) @(posedge clk);
    #1 trigger[2] = 1'b0;
    wait_done(2, 500);
    chk("t5_beat0", 2, log_w[2][0], 32'h0000_0001);
    chk("t5_beat1", 2, log_w[2][1], 32'h8020_0003);
    chk("t5_naw", 2, 32'(n_aw[2]), 32'd4);
    chk("t5_nbeats", 2, 32'(n_w[2]), 32'd64);

    // Reset in the middle of a data phase
    pulse(2);
    repeat (5) @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("t5_rst_wvalid", 2, 32'(wvalid[2]), 32'd0);
    chk("t5_rst_state", 2, 32'(dbg_state[2]), 32'd0);
    chk("t5_rst_busy", 2, 32'(busy[2]), 32'd0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    clear_logs(2);
    pulse(2);
    wait_done(2, 500);
    chk("t5_recover_beat0", 2, log_w[2][0], 32'h0000_0001);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
